// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan block.
// Glyph bits are {g,f,e,d,c,b,a}, active-high.
package seg_pkg;

  localparam int SEG_W = 8;

  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

  typedef enum logic [1:0] {
    BLANK = 2'd0,
    ON    = 2'd1,
    OFF   = 2'd2
  } state_e;

  typedef struct packed {
    logic       dp;
    logic [3:0] val;
  } digit_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to 7-segment glyph.
// Output order {g,f,e,d,c,b,a}, active-high.
module seg7_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg7
);

  always_comb begin
    seg7 = '0;
    unique case (nib)
      4'h0: seg7 = GLYPH_0;
      4'h1: seg7 = GLYPH_1;
      4'h2: seg7 = GLYPH_2;
      4'h3: seg7 = GLYPH_3;
      4'h4: seg7 = GLYPH_4;
      4'h5: seg7 = GLYPH_5;
      4'h6: seg7 = GLYPH_6;
      4'h7: seg7 = GLYPH_7;
      4'h8: seg7 = GLYPH_8;
      4'h9: seg7 = GLYPH_9;
      4'hA: seg7 = GLYPH_A;
      4'hB: seg7 = GLYPH_B;
      4'hC: seg7 = GLYPH_C;
      4'hD: seg7 = GLYPH_D;
      4'hE: seg7 = GLYPH_E;
      4'hF: seg7 = GLYPH_F;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan scheduler with double-buffered digits,
// brightness PWM and a blank dead time at the start of every slot.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int N_DIG = 8,
  parameter int DIV   = 100000,
  parameter int DEAD  = 500
) (
  input  logic             clk_M,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [2:0]       wr_addr,
  input  logic [3:0]       wr_data,
  input  logic             wr_dp,
  input  logic             commit,
  input  logic [7:0]       dig_en,
  input  logic [3:0]       bright,
  output logic [2:0]       Bit_Sel,
  output logic [SEG_W-1:0] seg,
  output logic             frame_tick
);

  // one spare bit so DEAD+on_len can reach DIV
  localparam int CW = $clog2(DIV) + 1;
  localparam logic [CW-1:0] LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] DEAD_C = CW'(DEAD);
  localparam logic [CW-1:0] STEP   = CW'((DIV - DEAD) >> 4);
  localparam logic [2:0]    DIG_LAST = 3'(N_DIG - 1);

  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_n;
  logic [CW-1:0]    on_len_q;
  logic [CW-1:0]    on_len;
  logic [2:0]       dig_q;
  logic [2:0]       dig_n;
  state_e           state_q;
  state_e           state_n;
  digit_t           shadow_q [8];
  digit_t           active_q [8];
  logic             commit_pend;
  logic             slot_end;
  logic             frame_end;
  logic             wr_fire;
  digit_t           cur;
  logic [6:0]       glyph;
  logic [SEG_W-1:0] seg_n;

  assign slot_end  = cnt_q == LAST;
  assign frame_end = slot_end && (dig_q == DIG_LAST);
  assign cnt_n     = slot_end ? '0 : cnt_q + CW'(1);

  assign dig_n = !slot_end ? dig_q :
                 (dig_q == DIG_LAST) ? 3'd0 :
                 dig_q + 3'd1;

  // on-window length is latched on the first cycle of a slot
  assign on_len = (cnt_q == '0) ? CW'(bright) * STEP
                                : on_len_q;

  assign wr_ready = ~commit_pend;
  assign wr_fire  = wr_valid && wr_ready &&
                    ({1'b0, wr_addr} < 4'(N_DIG));

  always_ff @(posedge clk_M) begin
    if (rst) state_q <= BLANK;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    if (slot_end) begin
      state_n = BLANK;
    end else begin
      unique case (state_q)
        BLANK: begin
          if (cnt_n == DEAD_C)
            state_n = (on_len != '0) ? ON : OFF;
        end
        ON: begin
          if (cnt_n == DEAD_C + on_len)
            state_n = OFF;
        end
        OFF:     state_n = OFF;
        default: state_n = BLANK;
      endcase
    end
  end

  assign cur = active_q[dig_q];

  seg7_hex_decode u_dec (
    .nib  (cur.val),
    .seg7 (glyph)
  );

  assign seg_n = (state_q == ON && dig_en[dig_q]) ?
                 {cur.dp, glyph} : '0;

  always_ff @(posedge clk_M) begin
    if (rst) begin
      cnt_q       <= '0;
      dig_q       <= '0;
      on_len_q    <= '0;
      Bit_Sel     <= '0;
      seg         <= '0;
      frame_tick  <= 1'b0;
      commit_pend <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      cnt_q      <= cnt_n;
      dig_q      <= dig_n;
      on_len_q   <= on_len;
      Bit_Sel    <= dig_q;
      seg        <= seg_n;
      frame_tick <= (cnt_n == LAST) && (dig_n == DIG_LAST);
      if (wr_fire)
        shadow_q[wr_addr] <= {wr_dp, wr_data};
      // writes are stalled while pending, so the copy sees a stable shadow
      if (commit_pend) begin
        if (frame_end) begin
          for (int i = 0; i < 8; i++)
            active_q[i] <= shadow_q[i];
          commit_pend <= 1'b0;
        end
      end else if (commit) begin
        commit_pend <= 1'b1;
      end
    end
  end

endmodule
